// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// Shared definitions for the NeoPixel stream sequencer and stream encoder:
// state encoding, default sizing and bit-timing limits.
package anton_neopixel_stream_sequencer_pkg;

  // Stream state as seen by the encoder.
  localparam logic [0:0] ENUM_STATE_RESET    = 1'b0;
  localparam logic [0:0] ENUM_STATE_TRANSMIT = 1'b1;

  // Default sizing.
  // 400 clocks at 7 MHz gives a latch period longer than 50 us.
  localparam int BUFFER_END_DEFAULT   = 255;
  localparam int RESET_CYCLES_DEFAULT = 400;

  // Each colour bit is 8 pattern slots, and each pixel is 24 colour bits.
  localparam logic [2:0] LAST_SLOT      = 3'd7;
  localparam logic [4:0] LAST_PIXEL_BIT = 5'd23;

  // Per-frame mode, captured when the frame starts.
  typedef struct packed {
    logic mode32;  // 4 bytes per pixel
    logic loop;    // repeat frames instead of requesting run clear
  } frameCfg_t;

endpackage

// File: rtl/anton_neopixel_stream_sequencer_bit_timer.sv
// Bit-timing cascade: the pattern slot (0..7) wraps into the pixel bit
// index (0..23). pixelDone marks the final slot of the final bit of a
// pixel, so the parent knows to advance pixelIndex on that same edge.
module anton_neopixel_stream_sequencer_bit_timer
  import anton_neopixel_stream_sequencer_pkg::*;
(
  input  logic       clk7mhz,
  input  logic       rstn,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] bitPatternIndex,
  output logic [4:0] pixelBitIndex,
  output logic       pixelDone
);

  logic [2:0] slot_r;
  logic [4:0] bit_r;

  // Slot counter cascading into the pixel bit counter; clear has priority.
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      slot_r <= 3'd0;
      bit_r  <= 5'd0;
    end else if (clear) begin
      slot_r <= 3'd0;
      bit_r  <= 5'd0;
    end else if (advance) begin
      slot_r <= slot_r + 3'd1;
      if (slot_r == LAST_SLOT) begin
        if (bit_r == LAST_PIXEL_BIT) begin
          bit_r <= 5'd0;
        end else begin
          bit_r <= bit_r + 5'd1;
        end
      end else begin
        bit_r <= bit_r;
      end
    end else begin
      slot_r <= slot_r;
      bit_r  <= bit_r;
    end
  end

  assign bitPatternIndex = slot_r;
  assign pixelBitIndex   = bit_r;
  assign pixelDone       = (slot_r == LAST_SLOT) && (bit_r == LAST_PIXEL_BIT);

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel stream sequencer. It runs the RESET/TRANSMIT state machine, the
// pixel byte index and the latch-period counter. Frame mode and the clamped
// end index are captured at frame start. The bit timer supplies the
// per-pixel bit and slot indices. 32-bit mode assumes BUFFER_END >= 4.
module anton_neopixel_stream_sequencer
  import anton_neopixel_stream_sequencer_pkg::*;
#(
  parameter  int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter  int RESET_CYCLES = RESET_CYCLES_DEFAULT,
  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1),
  localparam int RESET_BITS   = $clog2(RESET_CYCLES + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regMax,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   streamSyncOf,
  output logic                   regCtrlRunClear
);

  localparam logic [RESET_BITS-1:0]  RESET_LAST = RESET_BITS'(RESET_CYCLES - 1);
  localparam logic [BUFFER_BITS-1:0] END_LIMIT  = BUFFER_BITS'(BUFFER_END);

  logic [0:0]             seqState_r;
  logic [RESET_BITS-1:0]  resetCnt_r;
  logic [BUFFER_BITS-1:0] pixelIndex_r;
  logic [BUFFER_BITS-1:0] endIdx_r;
  frameCfg_t              frameCfg_r;
  logic                   streamSyncOf_r;
  logic                   runClear_r;

  logic                   pixelDone_s;
  logic                   lastPixel_s;
  logic                   frameStart_s;
  logic                   frameDone_s;
  logic                   abort_s;
  logic                   timerClear_s;
  logic                   timerAdvance_s;
  logic [BUFFER_BITS-1:0] clampedEnd_s;
  logic [BUFFER_BITS-1:0] pixelStep_s;

  // Clamp the requested end index to the physical buffer.
  always_comb begin
    clampedEnd_s = regMax;
    if (regMax > END_LIMIT) begin
      clampedEnd_s = END_LIMIT;
    end else begin
      clampedEnd_s = regMax;
    end
  end

  // The last-pixel test and the index step depend on the latched pixel width.
  always_comb begin
    lastPixel_s = 1'b0;
    pixelStep_s = BUFFER_BITS'(1);
    if (frameCfg_r.mode32) begin
      lastPixel_s = (pixelIndex_r[BUFFER_BITS-1:2] == endIdx_r[BUFFER_BITS-1:2]);
      pixelStep_s = BUFFER_BITS'(4);
    end else begin
      lastPixel_s = (pixelIndex_r == endIdx_r);
      pixelStep_s = BUFFER_BITS'(1);
    end
  end

  // State transition strobes. A normal frame end takes priority over run
  // falling on the same cycle, so the end-of-frame pulses are still sent.
  always_comb begin
    frameStart_s   = 1'b0;
    frameDone_s    = 1'b0;
    abort_s        = 1'b0;
    timerClear_s   = 1'b1;
    timerAdvance_s = 1'b0;
    if (seqState_r == ENUM_STATE_TRANSMIT) begin
      frameDone_s    = pixelDone_s && lastPixel_s;
      abort_s        = !regCtrlRun && !frameDone_s;
      timerClear_s   = abort_s;
      timerAdvance_s = 1'b1;
    end else begin
      frameStart_s   = (resetCnt_r == RESET_LAST) && regCtrlRun;
      timerClear_s   = 1'b1;
      timerAdvance_s = 1'b0;
    end
  end

  anton_neopixel_stream_sequencer_bit_timer bitTimer (
    .clk7mhz         (clk7mhz),
    .rstn            (rstn),
    .clear           (timerClear_s),
    .advance         (timerAdvance_s),
    .bitPatternIndex (bitPatternIndex),
    .pixelBitIndex   (pixelBitIndex),
    .pixelDone       (pixelDone_s)
  );

  // State machine, pixel index, latch counter, frame capture and pulses.
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      seqState_r     <= ENUM_STATE_RESET;
      resetCnt_r     <= '0;
      pixelIndex_r   <= '0;
      endIdx_r       <= '0;
      frameCfg_r     <= '0;
      streamSyncOf_r <= 1'b0;
      runClear_r     <= 1'b0;
    end else begin
      case (seqState_r)
        ENUM_STATE_RESET: begin
          streamSyncOf_r <= 1'b0;
          runClear_r     <= 1'b0;
          pixelIndex_r   <= '0;
          if (frameStart_s) begin
            seqState_r        <= ENUM_STATE_TRANSMIT;
            resetCnt_r        <= '0;
            endIdx_r          <= clampedEnd_s;
            frameCfg_r.mode32 <= regCtrl32bit;
            frameCfg_r.loop   <= regCtrlLoop;
          end else if (resetCnt_r != RESET_LAST) begin
            resetCnt_r <= resetCnt_r + RESET_BITS'(1);
          end else begin
            resetCnt_r <= resetCnt_r;
          end
        end
        ENUM_STATE_TRANSMIT: begin
          if (frameDone_s) begin
            seqState_r     <= ENUM_STATE_RESET;
            resetCnt_r     <= '0;
            pixelIndex_r   <= '0;
            streamSyncOf_r <= 1'b1;
            runClear_r     <= !frameCfg_r.loop;
          end else if (abort_s) begin
            seqState_r     <= ENUM_STATE_RESET;
            resetCnt_r     <= '0;
            pixelIndex_r   <= '0;
            streamSyncOf_r <= 1'b0;
            runClear_r     <= 1'b0;
          end else begin
            streamSyncOf_r <= 1'b0;
            runClear_r     <= 1'b0;
            if (pixelDone_s) begin
              pixelIndex_r <= pixelIndex_r + pixelStep_s;
            end else begin
              pixelIndex_r <= pixelIndex_r;
            end
          end
        end
        default: begin
          seqState_r     <= ENUM_STATE_RESET;
          resetCnt_r     <= '0;
          pixelIndex_r   <= '0;
          streamSyncOf_r <= 1'b0;
          runClear_r     <= 1'b0;
        end
      endcase
    end
  end

  assign state           = seqState_r;
  assign pixelIndex      = pixelIndex_r;
  assign streamSyncOf    = streamSyncOf_r;
  assign regCtrlRunClear = runClear_r;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Self-checking bench for the NeoPixel stream sequencer. A table of frame
// setups is run back to back. Expected frame results are queued when a setup
// is driven and compared when the frame finishes. Hand-written sequences
// cover run abort, async reset and clamping of the end index.
module tb_anton_neopixel_stream_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       regCtrlRun, regCtrlLoop, regCtrl32bit;
  logic [2:0] regMax;
  logic       state;
  logic [2:0] pixelIndex;
  logic [4:0] pixelBitIndex;
  logic [2:0] bitPatternIndex;
  logic       streamSyncOf, regCtrlRunClear;

  // second instance: BUFFER_END=5, used to check clamping of regMax
  logic       run2;
  logic       loop2 = 1'b0;
  logic       mode2 = 1'b0;
  logic [2:0] max2 = 3'd7;
  logic       state2;
  logic [2:0] pix2;
  logic [4:0] bit2;
  logic [2:0] slot2;
  logic       sync2, clr2;

  int vecs = 0;
  int miss = 0;

  typedef struct {
    bit       m32;
    bit [2:0] maxv;
    bit       loop;
    int       expLen;
    int       expLast;
    int       expClr;
  } vec_t;

  typedef struct {
    int len;
    int last;
    int clr;
    int gap;
  } exp_t;

  exp_t sbq[$];
  vec_t vtab[8];

  always #5 clk = ~clk;

  anton_neopixel_stream_sequencer #(.BUFFER_END(7), .RESET_CYCLES(16)) dut (
    .clk7mhz(clk), .rstn(rstn), .regCtrlRun(regCtrlRun), .regCtrlLoop(regCtrlLoop),
    .regCtrl32bit(regCtrl32bit), .regMax(regMax), .state(state), .pixelIndex(pixelIndex),
    .pixelBitIndex(pixelBitIndex), .bitPatternIndex(bitPatternIndex),
    .streamSyncOf(streamSyncOf), .regCtrlRunClear(regCtrlRunClear)
  );

  anton_neopixel_stream_sequencer #(.BUFFER_END(5), .RESET_CYCLES(16)) dut2 (
    .clk7mhz(clk), .rstn(rstn), .regCtrlRun(run2), .regCtrlLoop(loop2),
    .regCtrl32bit(mode2), .regMax(max2), .state(state2), .pixelIndex(pix2),
    .pixelBitIndex(bit2), .bitPatternIndex(slot2),
    .streamSyncOf(sync2), .regCtrlRunClear(clr2)
  );

  task automatic check(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Runs one frame from a RESET sample: drive setup, count latch gap,
  // follow the frame cycle by cycle, then score the end-of-frame sample.
  task automatic runFrame(input vec_t v);
    exp_t e;
    int gap, len, maxPix, idxErr, pulseErr, step, ePix;
    e.len = v.expLen; e.last = v.expLast; e.clr = v.expClr; e.gap = 16;
    sbq.push_back(e);
    regCtrl32bit = v.m32; regMax = v.maxv; regCtrlLoop = v.loop;
    gap = 0; pulseErr = 0;
    while (state == 1'b0 && gap < 200) begin
      gap++;
      if (gap > 1 && (streamSyncOf || regCtrlRunClear)) pulseErr++;
      @(negedge clk);
    end
    step = v.m32 ? 4 : 1;
    len = 0; maxPix = 0; idxErr = 0;
    while (state == 1'b1 && len < 4000) begin
      ePix = (len / 192) * step;
      if (bitPatternIndex != 3'(len % 8) || pixelBitIndex != 5'((len / 8) % 24) ||
          pixelIndex != 3'(ePix) || streamSyncOf || regCtrlRunClear) idxErr++;
      if (int'(pixelIndex) > maxPix) maxPix = int'(pixelIndex);
      // mid-frame register changes must not affect this frame
      if (len == 100) begin
        regCtrl32bit = !v.m32; regMax = ~v.maxv; regCtrlLoop = !v.loop;
      end
      len++;
      @(negedge clk);
    end
    e = sbq.pop_front();
    check("latchGap", gap, e.gap);
    check("frameLen", len, e.len);
    check("lastPixel", maxPix, e.last);
    check("indexSeq", idxErr, 0);
    check("gapPulses", pulseErr, 0);
    check("syncPulse", int'(streamSyncOf), 1);
    check("runClear", int'(regCtrlRunClear), e.clr);
    check("endIndices", int'({pixelIndex, pixelBitIndex, bitPatternIndex}), 0);
  endtask

  // Drops run at pixel 1 / bit 5 / slot 3, then optionally holds run low
  // before re-asserting it and measuring how long the restart takes.
  task automatic abortTest(input int hold, input int expGap);
    int n, err, gap;
    n = 0;
    while (!(state && pixelIndex == 3'd1 && pixelBitIndex == 5'd5 &&
             bitPatternIndex == 3'd3) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("abortPoint", int'(n < 3000), 1);
    regCtrlRun = 1'b0;
    @(negedge clk);
    check("abortState", int'({state, pixelIndex, pixelBitIndex, bitPatternIndex}), 0);
    check("abortPulses", int'({streamSyncOf, regCtrlRunClear}), 0);
    err = 0;
    for (int i = 0; i < hold; i++) begin
      if (state || streamSyncOf || regCtrlRunClear) err++;
      @(negedge clk);
    end
    check("holdInReset", err, 0);
    regCtrlRun = 1'b1;
    gap = 0;
    while (state == 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    check("restartGap", gap, expGap);
  endtask

  initial begin
    int n, gap, len, maxPix;
    vtab[0] = '{1'b0, 3'd2, 1'b0, 576,  2, 1};
    vtab[1] = '{1'b1, 3'd7, 1'b1, 384,  4, 0};
    vtab[2] = '{1'b0, 3'd7, 1'b0, 1536, 7, 1};
    vtab[3] = '{1'b1, 3'd5, 1'b0, 384,  4, 1};
    vtab[4] = '{1'b0, 3'd0, 1'b1, 192,  0, 0};
    vtab[5] = '{1'b1, 3'd2, 1'b0, 192,  0, 1};
    vtab[6] = '{1'b1, 3'd3, 1'b1, 192,  0, 0};
    vtab[7] = '{1'b0, 3'd1, 1'b1, 384,  1, 0};

    rstn = 1'b0; regCtrlRun = 1'b1; regCtrlLoop = 1'b0; regCtrl32bit = 1'b0;
    regMax = 3'd2; run2 = 1'b0;
    repeat (3) @(negedge clk);
    check("resetState", int'({state, pixelIndex, pixelBitIndex, bitPatternIndex,
                              streamSyncOf, regCtrlRunClear}), 0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) runFrame(vtab[i]);

    // run-abort corner cases
    regCtrl32bit = 1'b0; regMax = 3'd7; regCtrlLoop = 1'b1;
    gap = 0;
    while (state == 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    check("preAbortGap", gap, 16);
    abortTest(0, 16);
    abortTest(40, 1);

    // asynchronous reset mid-frame, checked before the next clock edge
    n = 0;
    while (pixelIndex != 3'd2 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("preAsyncPixel", int'(pixelIndex), 2);
    #2 rstn = 1'b0;
    #1 check("asyncReset", int'({state, pixelIndex, pixelBitIndex, bitPatternIndex,
                                 streamSyncOf, regCtrlRunClear}), 0);
    @(negedge clk);
    rstn = 1'b1;

    // end index clamp: regMax=7 on a buffer ending at 5
    run2 = 1'b1;
    gap = 0;
    while (state2 == 1'b0 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    check("clampGap", gap, 16);
    len = 0; maxPix = 0;
    while (state2 == 1'b1 && len < 3000) begin
      if (int'(pix2) > maxPix) maxPix = int'(pix2);
      len++;
      @(negedge clk);
    end
    check("clampLen", len, 1152);
    check("clampLast", maxPix, 5);
    check("clampSync", int'({sync2, clr2}), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
